// File: rtl/ysyx_22041752_pkg.sv
// Shared definitions for the ysyx_22041752 memory subsystem.
// Holds the SRAM port widths, the default widths of the memory arbiter,
// and the arbiter FSM state and owner encodings (IF=0, LS=1).
package ysyx_22041752_pkg;

  localparam int unsigned SRAM_ADDR_WD = 32;
  localparam int unsigned SRAM_DATA_WD = 64;
  localparam int unsigned SRAM_WEN_WD  = SRAM_DATA_WD / 8;

  localparam int unsigned ARB_ADDR_WD  = SRAM_ADDR_WD;
  localparam int unsigned ARB_DATA_WD  = SRAM_DATA_WD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ysyx_22041752_mem_arb.sv
// Two-requester arbiter in front of a single memory port.
// Instruction fetch (if_*) and load/store (ls_*) share one memory port with
// at most one outstanding transaction. Simultaneous requests are resolved
// round-robin against the last owner that received a memory grant.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   if_req/if_addr        fetch request; if_gnt accept; if_rvalid/if_rdata response
//   if_flush              discard any pending or outstanding fetch
//   ls_req/ls_wen/ls_addr/ls_wdata  load/store request (ls_wen==0: read)
//   ls_gnt accept; ls_rvalid/ls_rdata load data or store acknowledge
//   mem_req/mem_wen/mem_addr/mem_wdata  shared memory request; mem_gnt accept
//   mem_rvalid/mem_rdata  memory response, one per accepted request
module ysyx_22041752_mem_arb
  import ysyx_22041752_pkg::*;
#(
  parameter int unsigned ADDR_WD = ARB_ADDR_WD,
  parameter int unsigned DATA_WD = ARB_DATA_WD,
  parameter int unsigned WEN_WD  = DATA_WD / 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDR_WD-1:0] if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [DATA_WD-1:0] if_rdata,
  input  logic               if_flush,
  input  logic               ls_req,
  input  logic [WEN_WD-1:0]  ls_wen,
  input  logic [ADDR_WD-1:0] ls_addr,
  input  logic [DATA_WD-1:0] ls_wdata,
  output logic               ls_gnt,
  output logic               ls_rvalid,
  output logic [DATA_WD-1:0] ls_rdata,
  output logic               mem_req,
  output logic [WEN_WD-1:0]  mem_wen,
  output logic [ADDR_WD-1:0] mem_addr,
  output logic [DATA_WD-1:0] mem_wdata,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [DATA_WD-1:0] mem_rdata
);

  arb_state_e state, state_nxt;
  arb_owner_e owner, owner_nxt;
  arb_owner_e last_owner, last_owner_nxt;
  logic       drop, drop_nxt;

  logic if_live;
  logic own_if;
  logic flush_hit;

  // A flushed fetch never enters arbitration.
  assign if_live   = if_req & ~if_flush;
  assign own_if    = (owner == OWN_IF);
  assign flush_hit = own_if & if_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_IF;
      drop       <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      drop       <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    drop_nxt       = drop;
    mem_req        = 1'b0;
    mem_wen        = '0;
    mem_addr       = '0;
    mem_wdata      = '0;
    if_gnt         = 1'b0;
    ls_gnt         = 1'b0;
    if_rvalid      = 1'b0;
    if_rdata       = '0;
    ls_rvalid      = 1'b0;
    ls_rdata       = '0;

    unique case (state)
      ST_IDLE: begin
        if (if_live && ls_req) begin
          owner_nxt = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
          state_nxt = ST_REQ;
        end else if (if_live) begin
          owner_nxt = OWN_IF;
          state_nxt = ST_REQ;
        end else if (ls_req) begin
          owner_nxt = OWN_LS;
          state_nxt = ST_REQ;
        end
      end

      ST_REQ: begin
        if (flush_hit && !mem_gnt) begin
          // Fetch withdrawn before memory took it: drop the request outright.
          state_nxt = ST_IDLE;
        end else begin
          mem_req = 1'b1;
          if (own_if) begin
            mem_addr = if_addr;
          end else begin
            mem_wen   = ls_wen;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
          end
          if (mem_gnt) begin
            if_gnt         = own_if;
            ls_gnt         = ~own_if;
            last_owner_nxt = owner;
            // Memory already accepted it; the response must still be consumed.
            drop_nxt       = flush_hit;
            state_nxt      = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (flush_hit) drop_nxt = 1'b1;
        if (mem_rvalid) begin
          // A flush arriving together with the response also discards it.
          if (!(drop || flush_hit)) begin
            if (own_if) begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end else begin
              ls_rvalid = 1'b1;
              ls_rdata  = mem_rdata;
            end
          end
          state_nxt = ST_IDLE;
          drop_nxt  = 1'b0;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22041752_mem_arb.sv
module tb_ysyx_22041752_mem_arb;

  localparam bit PIF = 1'b0;
  localparam bit PLS = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, ls_req, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, ls_addr, mem_addr;
  logic [7:0]  ls_wen, mem_wen;
  logic [63:0] ls_wdata, mem_wdata, mem_rdata, if_rdata, ls_rdata;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req;

  int total = 0;
  int bad   = 0;
  logic [64:0] sb[$];   // {port, data}

  always #5 clk = ~clk;

  ysyx_22041752_mem_arb #(.ADDR_WD(32), .DATA_WD(64), .WEN_WD(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_flush(if_flush),
    .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_gnts_rvalids"}, {if_gnt, ls_gnt, if_rvalid, ls_rvalid}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wen"}, mem_wen, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rdata"}, if_rdata | ls_rdata, 0);
  endtask

  // Called right after the edge that leaves the arbiter in IDLE with the
  // requests already driven. Grants after gdly stalled REQ cycles and answers
  // rdly (>=1) cycles after the grant.
  task automatic txn(input bit own, input logic [31:0] addr, input logic [7:0] wen,
                     input logic [63:0] wd, input logic [63:0] rd,
                     input int gdly, input int rdly);
    @(negedge clk);
    chk("arb_cycle_no_req", mem_req, 0);
    nxt();
    for (int i = 0; i <= gdly; i++) begin
      mem_gnt = (i == gdly);
      @(negedge clk);
      chk("req_held", mem_req, 1);
      chk("req_addr", mem_addr, addr);
      chk("req_wen", mem_wen, wen);
      if (own == PLS) chk("req_wdata", mem_wdata, wd);
      chk("if_gnt", if_gnt, (i == gdly) && (own == PIF));
      chk("ls_gnt", ls_gnt, (i == gdly) && (own == PLS));
      nxt();
    end
    mem_gnt = 1'b0;
    if (own == PIF) if_req = 1'b0;
    else            ls_req = 1'b0;
    for (int k = 1; k < rdly; k++) begin
      @(negedge clk);
      chk("wait_no_req", mem_req, 0);
      nxt();
    end
    sb.push_back({own, rd});
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    @(negedge clk);
    chk("rsp_other_quiet", own == PIF ? ls_rvalid : if_rvalid, 0);
    nxt();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  // Response monitor: every rvalid must match the oldest expected response.
  always @(negedge clk) begin
    logic [64:0] e;
    if (reset === 1'b1) begin
      if (if_rvalid || ls_rvalid) begin
        if (sb.size() == 0) begin
          chk("spurious_rvalid", {if_rvalid, ls_rvalid}, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_port", {if_rvalid, ls_rvalid}, e[64] ? 2'b01 : 2'b10);
          chk("rsp_data", e[64] ? ls_rdata : if_rdata, e[63:0]);
        end
      end
      if (!if_rvalid) chk("if_rdata_zero", if_rdata, 0);
      if (!ls_rvalid) chk("ls_rdata_zero", ls_rdata, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; if_req = 1'b1; if_flush = 1'b0; ls_req = 1'b0;
    if_addr = 32'h8000_0000; ls_addr = '0; ls_wen = '0; ls_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset: outputs quiet even with a live request.
    @(negedge clk); chk_quiet("in_reset");
    @(negedge clk); chk_quiet("in_reset2");
    nxt(); reset = 1'b1; if_req = 1'b0;
    @(negedge clk); chk_quiet("after_reset");
    nxt();

    // Single fetch, minimum grant latency, response two cycles after grant.
    if_req = 1'b1; if_addr = 32'h8000_0000;
    txn(PIF, 32'h8000_0000, 8'h00, 64'h0, 64'h0000_0000_0000_0413, 0, 2);

    // Both requesting: LS, then IF, then LS again.
    if_req = 1'b1; if_addr = 32'h8000_0004;
    ls_req = 1'b1; ls_addr = 32'h8000_0100; ls_wen = 8'h00;
    txn(PLS, 32'h8000_0100, 8'h00, 64'h0, 64'hAAAA_0000_0000_0001, 0, 1);
    txn(PIF, 32'h8000_0004, 8'h00, 64'h0, 64'hBBBB_0000_0000_0002, 0, 1);
    if_req = 1'b1; if_addr = 32'h8000_0008;
    ls_req = 1'b1; ls_addr = 32'h8000_0200;
    txn(PLS, 32'h8000_0200, 8'h00, 64'h0, 64'hCCCC_0000_0000_0003, 0, 3);
    txn(PIF, 32'h8000_0008, 8'h00, 64'h0, 64'hDDDD_0000_0000_0004, 0, 1);

    // Store: payload passes through unchanged, ack on ls side.
    ls_req = 1'b1; ls_wen = 8'hFF; ls_addr = 32'h8000_1000;
    ls_wdata = 64'h1122_3344_5566_7788;
    txn(PLS, 32'h8000_1000, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 0, 2);
    ls_wen = '0; ls_wdata = '0;

    // Flush during WAIT discards the fetch; queued ls_req served next.
    if_req = 1'b1; if_addr = 32'h8000_0010;
    @(negedge clk); nxt();
    mem_gnt = 1'b1;
    @(negedge clk); chk("flushw_if_gnt", if_gnt, 1);
    nxt();
    mem_gnt = 1'b0; if_req = 1'b0; if_flush = 1'b1;
    ls_req = 1'b1; ls_addr = 32'h8000_2000;
    @(negedge clk); chk("flushw_wait_no_req", mem_req, 0);
    nxt();
    if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0000;
    @(negedge clk); chk("flushw_no_if_rvalid", if_rvalid, 0);
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    txn(PLS, 32'h8000_2000, 8'h00, 64'h0, 64'h0000_0000_5555_6666, 0, 1);

    // Flush in REQ before grant withdraws mem_req and returns to IDLE.
    if_req = 1'b1; if_addr = 32'h8000_0020;
    @(negedge clk); nxt();
    if_flush = 1'b1;
    @(negedge clk); chk("flushr_req_dropped", mem_req, 0);
    chk("flushr_no_gnt", if_gnt, 0);
    nxt();
    if_flush = 1'b0; if_addr = 32'h8000_0024;
    txn(PIF, 32'h8000_0024, 8'h00, 64'h0, 64'h0000_0000_7777_8888, 0, 1);

    // Reset while in WAIT abandons the transaction.
    if_req = 1'b1; if_addr = 32'h8000_0030;
    @(negedge clk); nxt();
    mem_gnt = 1'b1;
    @(negedge clk); nxt();
    mem_gnt = 1'b0; if_req = 1'b0;
    reset = 1'b0;
    @(negedge clk); chk_quiet("reset_in_wait");
    nxt();
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    @(negedge clk); chk("late_rvalid_ignored", {if_rvalid, ls_rvalid}, 0);
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    if_req = 1'b1; if_addr = 32'h8000_0034;
    txn(PIF, 32'h8000_0034, 8'h00, 64'h0, 64'h0000_0000_9999_AAAA, 0, 1);

    // Long grant stall: request and address held stable, no gnt out.
    if_req = 1'b1; if_addr = 32'h8000_0040;
    txn(PIF, 32'h8000_0040, 8'h00, 64'h0, 64'h0000_0000_BBBB_CCCC, 10, 1);

    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
